rename_unit_ckpt: RTL and testbench

- Parametrised register-rename stage between decode and dispatch in the OoO core.
- Maps architectural to physical registers through a RAT. Allocates destinations from a circular free-list FIFO and returns the previous mapping so commit can recycle it.
- Tracks per-physical-register ready bits with writeback wakeup and same-cycle bypass.
- Supports NUM_CKPT outstanding branch checkpoints, resolved out of order, with mispredict rollback of the RAT and free-list head.

---
 rtl/rename_unit_ckpt.sv | 181 ++++++++++++++++++
 tb/tb_rename_unit_ckpt.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rename_unit_ckpt.sv
// Register-rename stage: RAT lookup, free-list allocation, ready tracking and
// branch checkpoints with out-of-order resolution and mispredict rollback.
module rename_unit_ckpt #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int NUM_CKPT  = 4,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int PW = $clog2(PHYS_REGS),
  localparam int CW = $clog2(NUM_CKPT)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          dec_valid_i,
  output logic          dec_ready_o,
  input  logic          dec_rd_valid_i,
  input  logic [AW-1:0] dec_rd_idx_i,
  input  logic          dec_rs1_valid_i,
  input  logic [AW-1:0] dec_rs1_idx_i,
  input  logic          dec_rs2_valid_i,
  input  logic [AW-1:0] dec_rs2_idx_i,
  input  logic          dec_is_branch_i,
  output logic          ren_valid_o,
  output logic [PW-1:0] ren_rd_idx_o,
  output logic [PW-1:0] ren_rd_old_idx_o,
  output logic [PW-1:0] ren_rs1_idx_o,
  output logic          ren_rs1_ready_o,
  output logic [PW-1:0] ren_rs2_idx_o,
  output logic          ren_rs2_ready_o,
  output logic [CW-1:0] ren_ckpt_tag_o,
  input  logic          wb_valid_i,
  input  logic [PW-1:0] wb_idx_i,
  input  logic          cm_valid_i,
  input  logic [PW-1:0] cm_free_idx_i,
  input  logic          br_valid_i,
  input  logic [CW-1:0] br_tag_i,
  input  logic          br_mispred_i
);

  localparam int FD  = PHYS_REGS - ARCH_REGS;
  localparam int FIW = (FD > 1) ? $clog2(FD) : 1;
  localparam int FW  = FIW + 1;

  typedef logic [PW-1:0] preg_t;
  typedef logic [FW-1:0] ptr_t;

  preg_t               rat       [ARCH_REGS];
  preg_t               rat_after [ARCH_REGS];
  preg_t               fifo      [FD];
  logic [PHYS_REGS-1:0] ready, ready_next;
  ptr_t                head, tail, head_after;
  logic [FIW:0]        count;

  logic [NUM_CKPT-1:0] ckpt_valid, valid_next, kill;
  logic [NUM_CKPT-1:0] ckpt_mask [NUM_CKPT];
  logic [NUM_CKPT-1:0] mask_next [NUM_CKPT];
  preg_t               ckpt_rat  [NUM_CKPT][ARCH_REGS];
  ptr_t                ckpt_head [NUM_CKPT];

  logic          mispred, need_alloc, fire, alloc, ckpt_alloc, restore, push;
  logic          slot_free;
  logic [CW-1:0] free_slot;
  preg_t         new_idx, rs1_map, rs2_map;

  // Pointers count modulo FD; the top bit flips on each wrap to tell full from empty.
  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t r;
    if (p[FIW-1:0] == FIW'(FD - 1)) r = {~p[FW-1], {FIW{1'b0}}};
    else                            r = p + ptr_t'(1);
    return r;
  endfunction

  always_comb begin
    if (head[FW-1] == tail[FW-1])
      count = {1'b0, tail[FIW-1:0]} - {1'b0, head[FIW-1:0]};
    else
      count = (FIW+1)'(FD) - {1'b0, head[FIW-1:0]} + {1'b0, tail[FIW-1:0]};
  end

  always_comb begin
    slot_free = 1'b0;
    free_slot = '0;
    for (int s = NUM_CKPT - 1; s >= 0; s--) begin
      if (!ckpt_valid[s]) begin
        slot_free = 1'b1;
        free_slot = CW'(s);
      end
    end
  end

  assign mispred     = br_valid_i & br_mispred_i;
  assign need_alloc  = dec_rd_valid_i & (dec_rd_idx_i != '0);
  assign dec_ready_o = rst_ni & ~mispred & (~need_alloc | (count != '0))
                     & (~dec_is_branch_i | slot_free);
  assign fire        = dec_valid_i & dec_ready_o;
  assign alloc       = fire & need_alloc;
  assign ckpt_alloc  = fire & dec_is_branch_i;
  assign restore     = mispred & ckpt_valid[br_tag_i];
  assign push        = cm_valid_i & (cm_free_idx_i != '0) & (count != (FIW+1)'(FD));
  assign new_idx     = fifo[head[FIW-1:0]];

  always_comb begin
    rat_after = rat;
    if (alloc) rat_after[dec_rd_idx_i] = new_idx;
  end

  assign head_after = alloc ? ptr_inc(head) : head;

  // Allocation clears after writeback sets, so a same-cycle collision leaves the bit low.
  always_comb begin
    ready_next = ready;
    if (wb_valid_i) ready_next[wb_idx_i] = 1'b1;
    if (alloc)      ready_next[new_idx]  = 1'b0;
  end

  assign rs1_map = (dec_rs1_idx_i == '0) ? '0 : rat[dec_rs1_idx_i];
  assign rs2_map = (dec_rs2_idx_i == '0) ? '0 : rat[dec_rs2_idx_i];

  assign ren_valid_o      = fire;
  assign ren_rd_idx_o     = alloc ? new_idx : '0;
  assign ren_rd_old_idx_o = alloc ? rat[dec_rd_idx_i] : '0;
  assign ren_ckpt_tag_o   = ckpt_alloc ? free_slot : '0;
  assign ren_rs1_idx_o    = (fire & dec_rs1_valid_i) ? rs1_map : '0;
  assign ren_rs2_idx_o    = (fire & dec_rs2_valid_i) ? rs2_map : '0;
  assign ren_rs1_ready_o  = fire & dec_rs1_valid_i & ((dec_rs1_idx_i == '0) | ready[rs1_map]
                          | (wb_valid_i & (wb_idx_i == rs1_map)));
  assign ren_rs2_ready_o  = fire & dec_rs2_valid_i & ((dec_rs2_idx_i == '0) | ready[rs2_map]
                          | (wb_valid_i & (wb_idx_i == rs2_map)));

  // A mispredict squashes the slot and all its younger slots; a correct one frees only itself.
  always_comb begin
    kill = '0;
    if (br_valid_i && ckpt_valid[br_tag_i]) begin
      kill[br_tag_i] = 1'b1;
      if (br_mispred_i) kill = kill | ckpt_mask[br_tag_i];
    end
    valid_next = ckpt_valid & ~kill;
    for (int s = 0; s < NUM_CKPT; s++) mask_next[s] = ckpt_mask[s] & ~kill;
    if (ckpt_alloc) begin
      for (int s = 0; s < NUM_CKPT; s++)
        if (valid_next[s]) mask_next[s][free_slot] = 1'b1;
      mask_next[free_slot]  = '0;
      valid_next[free_slot] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ARCH_REGS; i++) rat[i] <= PW'(i);
      for (int i = 0; i < FD; i++) fifo[i] <= PW'(ARCH_REGS + i);
      for (int s = 0; s < NUM_CKPT; s++) ckpt_mask[s] <= '0;
      ready      <= {{FD{1'b0}}, {ARCH_REGS{1'b1}}};
      head       <= '0;
      tail       <= {1'b1, {FIW{1'b0}}};
      ckpt_valid <= '0;
    end else begin
      ready      <= ready_next;
      ckpt_valid <= valid_next;
      for (int s = 0; s < NUM_CKPT; s++) ckpt_mask[s] <= mask_next[s];
      if (restore) begin
        for (int i = 0; i < ARCH_REGS; i++) rat[i] <= ckpt_rat[br_tag_i][i];
        head <= ckpt_head[br_tag_i];
      end else begin
        for (int i = 0; i < ARCH_REGS; i++) rat[i] <= rat_after[i];
        head <= head_after;
      end
      if (push) begin
        fifo[tail[FIW-1:0]] <= cm_free_idx_i;
        tail                <= ptr_inc(tail);
      end
    end
  end

  // Snapshot storage holds no meaningful value until its slot is allocated.
  always_ff @(posedge clk_i) begin
    if (ckpt_alloc) begin
      for (int i = 0; i < ARCH_REGS; i++) ckpt_rat[free_slot][i] <= rat_after[i];
      ckpt_head[free_slot] <= head_after;
    end
  end

endmodule

// File: tb/tb_rename_unit_ckpt.sv
// Directed bench for rename_unit_ckpt: expected rename results are queued when
// an instruction is driven and popped when the unit reports a renamed instruction.
module tb_rename_unit_ckpt;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       dec_valid_i = 1'b0, dec_ready_o;
  logic       dec_rd_valid_i = 1'b0, dec_rs1_valid_i = 1'b0, dec_rs2_valid_i = 1'b0;
  logic [4:0] dec_rd_idx_i = '0, dec_rs1_idx_i = '0, dec_rs2_idx_i = '0;
  logic       dec_is_branch_i = 1'b0;
  logic       ren_valid_o, ren_rs1_ready_o, ren_rs2_ready_o;
  logic [5:0] ren_rd_idx_o, ren_rd_old_idx_o, ren_rs1_idx_o, ren_rs2_idx_o;
  logic [1:0] ren_ckpt_tag_o;
  logic       wb_valid_i = 1'b0, cm_valid_i = 1'b0, br_valid_i = 1'b0, br_mispred_i = 1'b0;
  logic [5:0] wb_idx_i = '0, cm_free_idx_i = '0;
  logic [1:0] br_tag_i = '0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] rd, rd_old, rs1, rs2;
    logic       rs1_rdy, rs2_rdy, chk_tag;
    logic [1:0] tag;
  } exp_t;

  exp_t sb[$];

  rename_unit_ckpt dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_rd_valid_i(dec_rd_valid_i), .dec_rd_idx_i(dec_rd_idx_i),
    .dec_rs1_valid_i(dec_rs1_valid_i), .dec_rs1_idx_i(dec_rs1_idx_i),
    .dec_rs2_valid_i(dec_rs2_valid_i), .dec_rs2_idx_i(dec_rs2_idx_i),
    .dec_is_branch_i(dec_is_branch_i),
    .ren_valid_o(ren_valid_o), .ren_rd_idx_o(ren_rd_idx_o),
    .ren_rd_old_idx_o(ren_rd_old_idx_o),
    .ren_rs1_idx_o(ren_rs1_idx_o), .ren_rs1_ready_o(ren_rs1_ready_o),
    .ren_rs2_idx_o(ren_rs2_idx_o), .ren_rs2_ready_o(ren_rs2_ready_o),
    .ren_ckpt_tag_o(ren_ckpt_tag_o),
    .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i),
    .cm_valid_i(cm_valid_i), .cm_free_idx_i(cm_free_idx_i),
    .br_valid_i(br_valid_i), .br_tag_i(br_tag_i), .br_mispred_i(br_mispred_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic exp_t mk(input int rd, input int old, input int rs1, input bit r1,
                              input int rs2, input bit r2, input bit ct, input int tag);
    exp_t e;
    e.rd = rd[5:0];   e.rd_old = old[5:0];
    e.rs1 = rs1[5:0]; e.rs1_rdy = r1;
    e.rs2 = rs2[5:0]; e.rs2_rdy = r2;
    e.chk_tag = ct;   e.tag = tag[1:0];
    return e;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one decode cycle (side inputs are set by the caller beforehand) and clears pulses after the edge.
  task automatic apply_stimulus(input bit valid, input bit rdv, input int rd,
                                input bit r1v, input int r1, input bit r2v, input int r2,
                                input bit isbr, input bit exp_ready, input exp_t e);
    exp_t got;
    dec_valid_i = valid;
    dec_rd_valid_i = rdv;   dec_rd_idx_i = rd[4:0];
    dec_rs1_valid_i = r1v;  dec_rs1_idx_i = r1[4:0];
    dec_rs2_valid_i = r2v;  dec_rs2_idx_i = r2[4:0];
    dec_is_branch_i = isbr;
    if (valid && exp_ready) sb.push_back(e);
    @(negedge clk_i);
    check_output("dec_ready", 32'(dec_ready_o), 32'(exp_ready));
    check_output("ren_valid", 32'(ren_valid_o), 32'(valid & exp_ready));
    if (ren_valid_o) begin
      check_output("sb_pending", 32'(sb.size()), 1);
      if (sb.size() > 0) begin
        got = sb.pop_front();
        check_output("rd_idx", 32'(ren_rd_idx_o), 32'(got.rd));
        check_output("rd_old", 32'(ren_rd_old_idx_o), 32'(got.rd_old));
        check_output("rs1_idx", 32'(ren_rs1_idx_o), 32'(got.rs1));
        check_output("rs1_ready", 32'(ren_rs1_ready_o), 32'(got.rs1_rdy));
        check_output("rs2_idx", 32'(ren_rs2_idx_o), 32'(got.rs2));
        check_output("rs2_ready", 32'(ren_rs2_ready_o), 32'(got.rs2_rdy));
        if (got.chk_tag) check_output("ckpt_tag", 32'(ren_ckpt_tag_o), 32'(got.tag));
      end
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
    @(posedge clk_i);
    #1;
    dec_valid_i = 1'b0;
    wb_valid_i = 1'b0;
    cm_valid_i = 1'b0;
    br_valid_i = 1'b0;
    br_mispred_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    dec_valid_i = 1'b1; dec_rd_valid_i = 1'b1; dec_rd_idx_i = 5'd1;
    #2;
    check_output("reset_dec_ready", 32'(dec_ready_o), 0);
    check_output("reset_ren_valid", 32'(ren_valid_o), 0);
    check_output("reset_rd_idx", 32'(ren_rd_idx_o), 0);
    check_output("reset_rd_old", 32'(ren_rd_old_idx_o), 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    dec_valid_i = 1'b0;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t none;
    none = mk(0, 0, 0, 0, 0, 0, 0, 0);

    // Basic rename, not-ready consumer, same-cycle bypass, x0 destination
    do_reset();
    apply_stimulus(1, 1, 1, 1, 2, 1, 3, 0, 1, mk(32, 1, 2, 1, 3, 1, 0, 0));
    apply_stimulus(1, 0, 0, 1, 1, 0, 0, 0, 1, mk(0, 0, 32, 0, 0, 0, 0, 0));
    wb_valid_i = 1'b1; wb_idx_i = 6'd32;
    apply_stimulus(1, 0, 0, 1, 1, 1, 0, 0, 1, mk(0, 0, 32, 1, 0, 1, 0, 0));
    apply_stimulus(1, 0, 0, 1, 1, 0, 0, 0, 1, mk(0, 0, 32, 1, 0, 0, 0, 0));
    apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, none);
    apply_stimulus(1, 1, 5, 0, 0, 0, 0, 0, 1, mk(33, 5, 0, 0, 0, 0, 0, 0));
    apply_stimulus(1, 1, 1, 0, 0, 0, 0, 0, 1, mk(34, 32, 0, 0, 0, 0, 0, 0));

    // Exhaust the free list; a zero commit must not refill it
    do_reset();
    for (int i = 0; i < 32; i++) begin
      if (i == 1) begin cm_valid_i = 1'b1; cm_free_idx_i = 6'd0; end
      apply_stimulus(1, 1, 1, 0, 0, 0, 0, 0, 1,
                     mk(32 + i, (i == 0) ? 1 : 31 + i, 0, 0, 0, 0, 0, 0));
    end
    apply_stimulus(1, 1, 2, 0, 0, 0, 0, 0, 0, none);
    cm_valid_i = 1'b1; cm_free_idx_i = 6'd1;
    apply_stimulus(0, 1, 2, 0, 0, 0, 0, 0, 0, none);
    apply_stimulus(1, 1, 2, 0, 0, 0, 0, 0, 1, mk(1, 2, 0, 0, 0, 0, 0, 0));

    // Mispredict restores RAT and free-list head
    do_reset();
    apply_stimulus(1, 1, 1, 0, 0, 0, 0, 0, 1, mk(32, 1, 0, 0, 0, 0, 0, 0));
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 1, 0));
    apply_stimulus(1, 1, 1, 0, 0, 0, 0, 0, 1, mk(33, 32, 0, 0, 0, 0, 0, 0));
    apply_stimulus(1, 1, 2, 0, 0, 0, 0, 0, 1, mk(34, 2, 0, 0, 0, 0, 0, 0));
    br_valid_i = 1'b1; br_tag_i = 2'd0; br_mispred_i = 1'b1;
    apply_stimulus(1, 0, 0, 1, 1, 0, 0, 0, 0, none);
    apply_stimulus(1, 0, 0, 1, 1, 1, 2, 0, 1, mk(0, 0, 32, 0, 2, 1, 0, 0));
    apply_stimulus(1, 1, 3, 0, 0, 0, 0, 0, 1, mk(33, 3, 0, 0, 0, 0, 0, 0));

    // Checkpoint slots: fill, stall, out-of-order free, full squash
    do_reset();
    for (int t = 0; t < 4; t++)
      apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 1, t));
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, none);
    br_valid_i = 1'b1; br_tag_i = 2'd1; br_mispred_i = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, none);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 1, 1));
    br_valid_i = 1'b1; br_tag_i = 2'd0; br_mispred_i = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, none);
    for (int t = 0; t < 4; t++)
      apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 1, t));
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, none);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
